spi_slave_sync: RTL and testbench

- Next-generation SPI target for the I/O module; replaces the multi-clock serializer with a fully synchronous, oversampled design.
- Runs on one fast clock. SPI_clock, SPI_mosi and SPI_cs_n are treated as asynchronous data inputs: they are synchronised and edge-detected, never used as clocks.
- Generalised in word width, SPI mode (CPOL/CPHA) and synchroniser depth.
- Adds a TX FIFO, underrun fill, frame start/end/abort reporting and a MISO output enable. Feeds the transaction handler.

---
 rtl/spi_slave_sync.sv | 219 +++++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
`timescale 1ns/1ps
// spi_slave_sync: oversampled SPI target; SCK/MOSI/CS are synchronised data inputs, with a TX FIFO and frame/underrun reporting.
// Latency: MISO updates SYNC_STAGES+1 cycles after the SCK pin edge; RX_valid one cycle after the completing sample edge is detected.
// Backpressure: TX_ready drops while the FIFO is full (pushes ignored); a word load on an empty FIFO sends all-ones and pulses TX_underrun.
module spi_slave_sync #(
    parameter int WORD_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int TX_DEPTH    = 4
) (
    input  logic              clock100,
    input  logic              reset_n,
    output logic              RX_valid,
    output logic [WORD_W-1:0] RX_data,
    input  logic              TX_valid,
    output logic              TX_ready,
    input  logic [WORD_W-1:0] TX_data,
    output logic              TX_underrun,
    output logic              frame_start,
    output logic              frame_end,
    output logic              frame_abort,
    input  logic              SPI_clock,
    input  logic              SPI_mosi,
    input  logic              SPI_cs_n,
    output logic              SPI_miso,
    output logic              SPI_miso_oe
);
    localparam int CW = $clog2(WORD_W);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int FW = PW + 1;
    localparam logic L_IDLE  = 1'(CPOL);
    localparam logic L_CPHA0 = (CPHA == 0);
    localparam logic [CW-1:0] L_LAST = CW'(WORD_W - 1);
    localparam logic [FW-1:0] L_FULL = FW'(TX_DEPTH);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    // synchronisers and edge-detect history
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   r_sck_d;
    logic                   r_cs_d;
    logic                   r_armed;

    // frame control and shift registers
    state_t            r_state;
    logic [CW-1:0]     r_bit_cnt;
    logic              r_load_pend;
    logic [WORD_W-1:0] r_tx_sh;
    logic [WORD_W-1:0] r_rx_sh;

    // TX FIFO
    logic [WORD_W-1:0] r_mem [TX_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [FW-1:0]     r_count;

    logic              w_sck;
    logic              w_cs;
    logic              w_mosi;
    logic              w_sck_lead;
    logic              w_sck_trail;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic              w_start;
    logic              w_run;
    logic              w_sample;
    logic              w_shift;
    logic              w_word_start;
    logic              w_load;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;
    logic [WORD_W-1:0] w_rx_next;

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_sck_lead  = (w_sck != r_sck_d) && (w_sck != L_IDLE);
    assign w_sck_trail = (w_sck != r_sck_d) && (w_sck == L_IDLE);
    assign w_cs_fall   = r_cs_d & ~w_cs;
    assign w_cs_rise   = ~r_cs_d & w_cs;

    // SCK edges only count inside an armed frame; the CS-fall cycle itself is still IDLE so its edges drop out
    assign w_start  = w_cs_fall & r_armed & (r_state == S_IDLE);
    assign w_run    = (r_state == S_ACTIVE) & ~w_cs;
    assign w_sample = w_run & (L_CPHA0 ? w_sck_lead : w_sck_trail);
    assign w_shift  = w_run & (L_CPHA0 ? w_sck_trail : w_sck_lead);

    // CPHA=0 reloads on the shift edge right after a word completes; CPHA=1 on the first shift edge of a word
    assign w_word_start = L_CPHA0 ? r_load_pend : (r_bit_cnt == '0);
    assign w_load       = (L_CPHA0 & w_start) | (w_shift & w_word_start);

    assign w_fifo_empty = (r_count == '0);
    assign TX_ready     = (r_count != L_FULL);
    assign w_push       = TX_valid & TX_ready;
    assign w_pop        = w_load & ~w_fifo_empty;

    assign w_rx_next = {r_rx_sh[WORD_W-2:0], w_mosi};
    assign SPI_miso  = r_tx_sh[WORD_W-1];

    // pin synchronisers; r_sync_vld marks when the last stage holds a real pin sample rather than a reset value
    always_ff @(posedge clock100 or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_sync  <= {SYNC_STAGES{L_IDLE}};
            r_cs_sync   <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= '0;
            r_sync_vld  <= '0;
            r_sck_d     <= L_IDLE;
            r_cs_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SPI_clock};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], SPI_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_mosi};
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs;
        end
    end

    // arm only after a genuine CS-high observation, so a frame already running at reset release is ignored
    always_ff @(posedge clock100 or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b0;
        end else if (w_cs && r_sync_vld[SYNC_STAGES-1]) begin
            r_armed <= 1'b1;
        end
    end

    // frame FSM with TX/RX shift registers and registered status pulses
    always_ff @(posedge clock100 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_load_pend <= 1'b0;
            r_tx_sh     <= '1;
            r_rx_sh     <= '0;
            RX_data     <= '0;
            RX_valid    <= 1'b0;
            TX_underrun <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_abort <= 1'b0;
            SPI_miso_oe <= 1'b0;
        end else begin
            RX_valid    <= 1'b0;
            TX_underrun <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_abort <= 1'b0;

            if (w_load) begin
                r_tx_sh     <= w_fifo_empty ? {WORD_W{1'b1}} : r_mem[r_rd_ptr];
                TX_underrun <= w_fifo_empty;
            end else if (w_shift) begin
                r_tx_sh <= {r_tx_sh[WORD_W-2:0], 1'b1};
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_ACTIVE;
                        frame_start <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_load_pend <= 1'b0;
                        SPI_miso_oe <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_cs_rise) begin
                        // partial RX word and any loaded TX word are dropped here
                        r_state     <= S_IDLE;
                        frame_end   <= 1'b1;
                        frame_abort <= (r_bit_cnt != '0);
                        r_bit_cnt   <= '0;
                        r_load_pend <= 1'b0;
                        SPI_miso_oe <= 1'b0;
                    end else if (w_sample) begin
                        r_rx_sh <= w_rx_next;
                        if (r_bit_cnt == L_LAST) begin
                            r_bit_cnt   <= '0;
                            RX_data     <= w_rx_next;
                            RX_valid    <= 1'b1;
                            r_load_pend <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end
                    end else if (w_shift && w_word_start) begin
                        r_load_pend <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; a pop on an empty FIFO never bypasses a same-cycle push
    always_ff @(posedge clock100 or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset is needed
    always_ff @(posedge clock100) begin
        if (w_push) r_mem[r_wr_ptr] <= TX_data;
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
`timescale 1ns/1ps
// tb_spi_slave_sync: one DUT per SPI mode (index = CPOL*2 + CPHA), driven by a bit-level SPI master task.
// Expected values come from a constant vector table and a transaction-level FIFO/frame model.
// All waits are fixed-length, so the run always reaches its summary line.
module tb_spi_slave_sync;
    localparam int W = 8;
    localparam int H = 5;   // SCK half period in clock100 cycles

    typedef logic [5:0][7:0] wv_t;   // word 0 in the low byte

    typedef struct packed {
        logic [1:0] mode;
        logic [2:0] npush;
        wv_t        pd;
        logic [5:0] nbits;
        wv_t        mw;
        wv_t        em;
        logic [2:0] und;
        logic       abrt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]      sck, mosi, cs_n, tx_vld;
    logic [3:0]      rx_vld, tx_rdy, und, fs, fe, fa, miso, oe;
    logic [3:0][7:0] tx_dat, rx_dat;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_sync #(
            .WORD_W(W), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2), .TX_DEPTH(4)
        ) u_dut (
            .clock100(clk), .reset_n(rst_n),
            .RX_valid(rx_vld[g]), .RX_data(rx_dat[g]),
            .TX_valid(tx_vld[g]), .TX_ready(tx_rdy[g]), .TX_data(tx_dat[g]),
            .TX_underrun(und[g]), .frame_start(fs[g]), .frame_end(fe[g]), .frame_abort(fa[g]),
            .SPI_clock(sck[g]), .SPI_mosi(mosi[g]), .SPI_cs_n(cs_n[g]),
            .SPI_miso(miso[g]), .SPI_miso_oe(oe[g])
        );
    end

    int   n_vec = 0;
    int   n_err = 0;
    int   fs_c[4], fe_c[4], fa_c[4], und_c[4], rx_c[4];
    logic [7:0] rx_log [4][256];
    logic [7:0] mq [4][$];   // reference TX FIFO contents per mode
    vec_t tbl [8];

    // pulse and RX-word monitor, sampled away from the active edge
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (fs[m])  fs_c[m]++;
            if (fe[m])  fe_c[m]++;
            if (fa[m])  fa_c[m]++;
            if (und[m]) und_c[m]++;
            if (rx_vld[m]) begin
                rx_log[m][rx_c[m] % 256] = rx_dat[m];
                rx_c[m]++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int m, input logic [7:0] d);
        chk($sformatf("tx_ready m%0d", m), 32'(tx_rdy[m]), 32'(mq[m].size() < 4));
        if (mq[m].size() < 4) mq[m].push_back(d);
        tx_vld[m] = 1'b1;
        tx_dat[m] = d;
        wait_clk(1);
        tx_vld[m] = 1'b0;
    endtask

    task automatic drive_frame(input int m, input int nbits, input wv_t mw,
                               output wv_t sw, output logic oe_mid);
        logic cpol;
        logic b;
        cpol   = 1'(m / 2);
        sw     = '0;
        oe_mid = 1'b0;
        cs_n[m] = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nbits; i++) begin
            b = mw[i / 8][7 - (i % 8)];
            if (m % 2 == 0) begin
                mosi[m] = b;
                wait_clk(H);
                sw[i / 8][7 - (i % 8)] = miso[m];
                sck[m] = ~cpol;
                wait_clk(H);
                sck[m] = cpol;
            end else begin
                sck[m]  = ~cpol;
                mosi[m] = b;
                wait_clk(H);
                sw[i / 8][7 - (i % 8)] = miso[m];
                sck[m] = cpol;
                wait_clk(H);
            end
            if (i == 0) oe_mid = oe[m];
        end
        wait_clk(H);
        cs_n[m] = 1'b1;
        wait_clk(12);
    endtask

    task automatic do_frame(input int m, input int nbits, input wv_t mw, input wv_t em,
                            input int eund, input logic eab, input string tag);
        wv_t  sw;
        logic oe_mid;
        logic [7:0] mask;
        int fs0, fe0, fa0, und0, rx0, full, part;
        fs0 = fs_c[m]; fe0 = fe_c[m]; fa0 = fa_c[m]; und0 = und_c[m]; rx0 = rx_c[m];
        full = nbits / 8;
        part = nbits % 8;
        drive_frame(m, nbits, mw, sw, oe_mid);
        chk({tag, " frame_start"}, fs_c[m] - fs0, 1);
        chk({tag, " frame_end"}, fe_c[m] - fe0, 1);
        chk({tag, " frame_abort"}, fa_c[m] - fa0, 32'(eab));
        chk({tag, " underrun"}, und_c[m] - und0, eund);
        chk({tag, " rx_count"}, rx_c[m] - rx0, full);
        chk({tag, " oe_active"}, 32'(oe_mid), 1);
        chk({tag, " oe_idle"}, 32'(oe[m]), 0);
        for (int k = 0; k < full; k++) begin
            chk($sformatf("%s rx_word%0d", tag, k), rx_log[m][(rx0 + k) % 256], mw[k]);
            chk($sformatf("%s miso_word%0d", tag, k), sw[k], em[k]);
        end
        if (part > 0) begin
            mask = 8'hFF << (8 - part);
            chk({tag, " miso_partial"}, sw[full] & mask, em[full] & mask);
        end
    endtask

    // transaction-level expectation: each word load takes the FIFO head or all-ones
    task automatic model_frame(input int m, input int nbits, input wv_t mw, input string tag);
        wv_t em;
        int full, part, pops, nund;
        em   = '1;
        full = nbits / 8;
        part = nbits % 8;
        nund = 0;
        pops = (m % 2 == 0) ? full + 1 : full + ((part > 0) ? 1 : 0);
        for (int k = 0; k < pops; k++) begin
            if (mq[m].size() > 0) em[k] = mq[m].pop_front();
            else begin
                em[k] = 8'hFF;
                nund++;
            end
        end
        do_frame(m, nbits, mw, em, nund, part > 0, tag);
    endtask

    initial begin
        wv_t mw;
        int  m, np, nbits;
        int  fs0, fe0, rx0;

        tbl[0] = '{mode:2'd0, npush:3'd1, pd:48'hA5, nbits:6'd8, mw:48'h3C, em:48'hA5, und:3'd1, abrt:1'b0};
        tbl[1] = '{mode:2'd1, npush:3'd2, pd:48'h7E81, nbits:6'd16, mw:48'h3412, em:48'h7E81, und:3'd0, abrt:1'b0};
        tbl[2] = '{mode:2'd2, npush:3'd2, pd:48'h7E81, nbits:6'd16, mw:48'h3412, em:48'h7E81, und:3'd1, abrt:1'b0};
        tbl[3] = '{mode:2'd3, npush:3'd2, pd:48'h7E81, nbits:6'd16, mw:48'h3412, em:48'h7E81, und:3'd0, abrt:1'b0};
        tbl[4] = '{mode:2'd1, npush:3'd0, pd:48'h0, nbits:6'd16, mw:48'h3CC3, em:48'hFFFF, und:3'd2, abrt:1'b0};
        tbl[5] = '{mode:2'd0, npush:3'd5, pd:48'hE5D4C3B2A1, nbits:6'd32, mw:48'h08040201, em:48'hD4C3B2A1, und:3'd1, abrt:1'b0};
        tbl[6] = '{mode:2'd0, npush:3'd0, pd:48'h0, nbits:6'd5, mw:48'hA8, em:48'hFF, und:3'd1, abrt:1'b1};
        tbl[7] = '{mode:2'd0, npush:3'd1, pd:48'h5A, nbits:6'd8, mw:48'h96, em:48'h5A, und:3'd1, abrt:1'b0};

        rst_n  = 1'b0;
        sck    = 4'b1100;
        cs_n   = 4'b1111;
        mosi   = 4'b0000;
        tx_vld = 4'b0000;
        tx_dat = '0;
        wait_clk(4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset tx_ready m%0d", i), 32'(tx_rdy[i]), 1);
            chk($sformatf("reset miso m%0d", i), 32'(miso[i]), 1);
            chk($sformatf("reset oe m%0d", i), 32'(oe[i]), 0);
            chk($sformatf("reset rx_data m%0d", i), rx_dat[i], 0);
        end
        rst_n = 1'b1;
        wait_clk(10);

        // directed vectors
        for (int t = 0; t < 8; t++) begin
            for (int p = 0; p < int'(tbl[t].npush); p++) push(tbl[t].mode, tbl[t].pd[p]);
            do_frame(tbl[t].mode, tbl[t].nbits, tbl[t].mw, tbl[t].em, tbl[t].und, tbl[t].abrt,
                     $sformatf("vec%0d", t));
            mq[tbl[t].mode].delete();
        end

        // randomized frames against the reference model
        for (int r = 0; r < 32; r++) begin
            m  = $urandom_range(0, 3);
            np = $urandom_range(0, 5);
            for (int p = 0; p < np; p++) push(m, 8'($urandom));
            nbits = 8 * $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) nbits = nbits - $urandom_range(1, 7);
            for (int k = 0; k < 6; k++) mw[k] = 8'($urandom);
            model_frame(m, nbits, mw, $sformatf("rnd%0d m%0d", r, m));
        end

        // reset asserted mid-word with CS held low
        cs_n[0] = 1'b0;
        mosi[0] = 1'b1;
        wait_clk(H);
        for (int i = 0; i < 3; i++) begin
            sck[0] = 1'b1; wait_clk(H);
            sck[0] = 1'b0; wait_clk(H);
        end
        rst_n = 1'b0;
        wait_clk(3);
        chk("midrst rx_valid", 32'(rx_vld[0]), 0);
        chk("midrst rx_data", rx_dat[0], 0);
        chk("midrst tx_ready", 32'(tx_rdy[0]), 1);
        chk("midrst miso", 32'(miso[0]), 1);
        chk("midrst oe", 32'(oe[0]), 0);
        fs0 = fs_c[0]; fe0 = fe_c[0]; rx0 = rx_c[0];
        for (int i = 0; i < 8; i++) begin
            sck[0] = 1'b1; wait_clk(H);
            if (i == 1) rst_n = 1'b1;
            sck[0] = 1'b0; wait_clk(H);
            chk($sformatf("postrst oe bit%0d", i), 32'(oe[0]), 0);
        end
        wait_clk(H);
        chk("postrst no frame_start", fs_c[0] - fs0, 0);
        chk("postrst no rx_valid", rx_c[0] - rx0, 0);
        chk("postrst rx_data", rx_dat[0], 0);
        cs_n[0] = 1'b1;
        wait_clk(12);
        chk("postrst no frame_end", fe_c[0] - fe0, 0);
        for (int i = 0; i < 4; i++) mq[i].delete();
        mw = 48'h69;
        push(0, 8'hC3);
        model_frame(0, 8, mw, "postrst frame");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
